// File: rtl/dot_accum_pkg.sv
// Shared definitions for the frame-sum accumulator.
// Holds default widths and the control state encoding.
package dot_accum_pkg;

  localparam int unsigned DEFAULT_IN_W  = 17;
  localparam int unsigned DEFAULT_LEN_W = 4;
  localparam int unsigned DEFAULT_ACC_W = DEFAULT_IN_W + DEFAULT_LEN_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/dot_accum.sv
// Frame-sum accumulator: adds N unsigned dot-product results per frame
// and presents the sum until the downstream consumer takes it.
// Ports:
//   iCLK, iRST      clock, synchronous active-high reset
//   iVALID/oREADY   upstream handshake carrying iR
//   iLEN            frame length, sampled on the first beat (0 = 2^LEN_W)
//   iCLR            synchronous frame abort
//   oSUM/oVALID     completed frame sum, held until iREADY
module dot_accum
  import dot_accum_pkg::*;
#(
  parameter int unsigned IN_W  = DEFAULT_IN_W,
  parameter int unsigned LEN_W = DEFAULT_LEN_W,
  parameter int unsigned ACC_W = IN_W + LEN_W
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iVALID,
  input  logic [IN_W-1:0]  iR,
  output logic             oREADY,
  input  logic [LEN_W-1:0] iLEN,
  input  logic             iCLR,
  output logic [ACC_W-1:0] oSUM,
  output logic             oVALID,
  input  logic             iREADY
);

  // Counter and length need one extra bit to represent 2^LEN_W.
  localparam int unsigned CNT_W = LEN_W + 1;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic               valid_q, valid_d;
  logic               ready_q, ready_d;

  logic               beat_c;
  logic [CNT_W-1:0]   first_len_c;

  assign beat_c      = iVALID && ready_q;
  // A zero length field encodes the maximum frame of 2^LEN_W results.
  assign first_len_c = (iLEN == '0) ? {1'b1, {LEN_W{1'b0}}} : CNT_W'(iLEN);

  // Next-state, accumulator and handshake flags.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;

    if (iCLR) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      len_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (beat_c) begin
            len_d   = first_len_c;
            acc_d   = ACC_W'(iR);
            cnt_d   = CNT_W'(1);
            state_d = (first_len_c == CNT_W'(1)) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (beat_c) begin
            acc_d = acc_q + ACC_W'(iR);
            cnt_d = cnt_q + CNT_W'(1);
            if ((cnt_q + CNT_W'(1)) == len_q) state_d = DONE;
          end
        end
        DONE: begin
          if (iREADY) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // Flags are registered copies of the next-state decode.
    ready_d = (state_d != DONE);
    valid_d = (state_d == DONE);
  end

  // State register.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign oSUM   = acc_q;
  assign oVALID = valid_q;
  assign oREADY = ready_q;

endmodule

// File: tb/tb_dot_accum.sv
// Self-checking bench for dot_accum: directed frame scenarios plus a
// randomized run against a queue-based frame model.
module tb_dot_accum;

  localparam int unsigned IN_W  = 17;
  localparam int unsigned LEN_W = 4;
  localparam int unsigned ACC_W = 21;

  logic             iCLK = 1'b0;
  logic             iRST;
  logic             iVALID;
  logic [IN_W-1:0]  iR;
  logic             oREADY;
  logic [LEN_W-1:0] iLEN;
  logic             iCLR;
  logic [ACC_W-1:0] oSUM;
  logic             oVALID;
  logic             iREADY;

  int checks = 0;
  int errors = 0;

  dot_accum #(.IN_W(IN_W), .LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iVALID (iVALID),
    .iR     (iR),
    .oREADY (oREADY),
    .iLEN   (iLEN),
    .iCLR   (iCLR),
    .oSUM   (oSUM),
    .oVALID (oVALID),
    .iREADY (iREADY)
  );

  always #5 iCLK = ~iCLK;

  // Advance one edge; inputs change and outputs are sampled 1 unit later.
  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic idle_inputs();
    iRST = 1'b0; iVALID = 1'b0; iR = '0; iLEN = '0; iCLR = 1'b0; iREADY = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    iRST = 1'b1;
    step();
    iRST = 1'b0;
  endtask

  task automatic beat(input logic [IN_W-1:0] r);
    iVALID = 1'b1; iR = r;
    step();
    iVALID = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (oVALID !== 1'b0 || oREADY !== 1'b1 || oSUM !== '0) begin
      errors++;
      $display("FAIL reset: valid=%b ready=%b sum=%0d, want valid=0 ready=1 sum=0", oVALID, oREADY, oSUM);
    end
  endtask

  task automatic test_basic();
    do_reset();
    iLEN = 4'd3;
    beat(17'd10);
    beat(17'd20);
    checks++;
    if (oVALID !== 1'b0) begin
      errors++; $display("FAIL basic_early: valid=%b want 0", oVALID);
    end
    beat(17'd30);
    checks++;
    if (oVALID !== 1'b1 || oSUM !== 21'd60) begin
      errors++; $display("FAIL basic_done: valid=%b sum=%0d want valid=1 sum=60", oVALID, oSUM);
    end
    step();
    checks++;
    if (oVALID !== 1'b0 || oREADY !== 1'b1) begin
      errors++; $display("FAIL basic_drain: valid=%b ready=%b want 0/1", oVALID, oREADY);
    end
  endtask

  task automatic test_max_len();
    do_reset();
    iLEN = '0;
    for (int i = 0; i < 15; i++) beat(17'h1FFFF);
    checks++;
    if (oVALID !== 1'b0 || oSUM !== 21'h1FFFF * 15) begin
      errors++; $display("FAIL max_partial: valid=%b sum=%h want 0 / %h", oVALID, oSUM, 21'h1FFFF * 15);
    end
    beat(17'h1FFFF);
    checks++;
    if (oVALID !== 1'b1 || oSUM !== 21'h1FFFF0) begin
      errors++; $display("FAIL max_len: valid=%b sum=%h want 1 / 1ffff0", oVALID, oSUM);
    end
  endtask

  task automatic test_hold();
    do_reset();
    iLEN = 4'd1;
    iREADY = 1'b0;
    beat(17'd5);
    for (int i = 0; i < 4; i++) begin
      iVALID = 1'b1; iR = 17'd99;
      checks++;
      if (oVALID !== 1'b1 || oREADY !== 1'b0 || oSUM !== 21'd5) begin
        errors++; $display("FAIL hold[%0d]: valid=%b ready=%b sum=%0d want 1/0/5", i, oVALID, oREADY, oSUM);
      end
      step();
    end
    iVALID = 1'b0;
    checks++;
    if (oVALID !== 1'b1 || oSUM !== 21'd5) begin
      errors++; $display("FAIL hold_end: valid=%b sum=%0d want 1/5", oVALID, oSUM);
    end
    iREADY = 1'b1;
    step();
    checks++;
    if (oVALID !== 1'b0 || oREADY !== 1'b1 || oSUM !== 21'd5) begin
      errors++; $display("FAIL hold_release: valid=%b ready=%b sum=%0d want 0/1/5", oVALID, oREADY, oSUM);
    end
  endtask

  task automatic test_gap_len();
    do_reset();
    iLEN = 4'd2;
    beat(17'd7);
    for (int c = 1; c < 5; c++) begin
      if (c >= 2) iLEN = 4'd9;
      step();
      checks++;
      if (oVALID !== 1'b0 || oSUM !== 21'd7) begin
        errors++; $display("FAIL gap[%0d]: valid=%b sum=%0d want 0/7", c, oVALID, oSUM);
      end
    end
    beat(17'd8);
    checks++;
    if (oVALID !== 1'b1 || oSUM !== 21'd15) begin
      errors++; $display("FAIL gap_len: valid=%b sum=%0d want 1/15", oVALID, oSUM);
    end
  endtask

  task automatic test_clear();
    do_reset();
    iLEN = 4'd4;
    beat(17'd1);
    beat(17'd2);
    iCLR = 1'b1;
    beat(17'd100);
    iCLR = 1'b0;
    checks++;
    if (oVALID !== 1'b0 || oREADY !== 1'b1 || oSUM !== '0) begin
      errors++; $display("FAIL clear: valid=%b ready=%b sum=%0d want 0/1/0", oVALID, oREADY, oSUM);
    end
    iLEN = 4'd1;
    beat(17'd9);
    checks++;
    if (oVALID !== 1'b1 || oSUM !== 21'd9) begin
      errors++; $display("FAIL clear_next: valid=%b sum=%0d want 1/9", oVALID, oSUM);
    end
  endtask

  task automatic test_reset_in_done();
    do_reset();
    iLEN = 4'd1;
    iREADY = 1'b0;
    beat(17'd42);
    checks++;
    if (oVALID !== 1'b1 || oSUM !== 21'd42) begin
      errors++; $display("FAIL rst_done_pre: valid=%b sum=%0d want 1/42", oVALID, oSUM);
    end
    iRST = 1'b1; iVALID = 1'b1; iR = 17'd3;
    step();
    iRST = 1'b0; iVALID = 1'b0; iREADY = 1'b1;
    checks++;
    if (oVALID !== 1'b0 || oREADY !== 1'b1 || oSUM !== '0) begin
      errors++; $display("FAIL rst_done: valid=%b ready=%b sum=%0d want 0/1/0", oVALID, oREADY, oSUM);
    end
  endtask

  // Frame model: accepted beats of the open frame live in a queue;
  // the frame completes when the queue reaches the sampled length.
  task automatic test_random();
    longint frame_q[$];
    int     target;
    logic   exp_valid;
    longint exp_sum;
    bit     acc;
    do_reset();
    frame_q.delete();
    target = 0; exp_valid = 1'b0; exp_sum = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      iRST   = ($urandom_range(0, 99) < 2);
      iCLR   = ($urandom_range(0, 99) < 3);
      iVALID = ($urandom_range(0, 99) < 70);
      iR     = IN_W'($urandom);
      iLEN   = ($urandom_range(0, 9) == 0) ? LEN_W'(0) : LEN_W'($urandom_range(1, 5));
      iREADY = ($urandom_range(0, 99) < 60);

      acc = iVALID && !exp_valid;
      if (iRST || iCLR) begin
        frame_q.delete(); target = 0; exp_valid = 1'b0; exp_sum = 0;
      end else if (exp_valid) begin
        if (iREADY) exp_valid = 1'b0;
      end else if (acc) begin
        if (frame_q.size() == 0) target = (iLEN == 0) ? (1 << LEN_W) : int'(iLEN);
        frame_q.push_back(longint'(iR));
        exp_sum = 0;
        foreach (frame_q[k]) exp_sum += frame_q[k];
        if (frame_q.size() == target) begin
          exp_valid = 1'b1;
          frame_q.delete();
        end
      end

      step();
      checks++;
      if (oVALID !== exp_valid || oREADY !== !exp_valid || oSUM !== ACC_W'(exp_sum)) begin
        errors++;
        $display("FAIL random[%0d]: valid=%b ready=%b sum=%0d want %b/%b/%0d",
                 cyc, oVALID, oREADY, oSUM, exp_valid, !exp_valid, exp_sum);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    test_max_len();
    test_hold();
    test_gap_len();
    test_clear();
    test_reset_in_done();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
